// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fft_state_t;

  localparam int N_LOG2_DEFAULT   = 5;
  localparam int PIPE_LAT_DEFAULT = 2;

  function automatic int fft_n(input int n_log2);
    return 1 << n_log2;
  endfunction

  function automatic int fft_half_n(input int n_log2);
    return fft_n(n_log2) / 2;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage s, butterfly k) -> A/B addresses and twiddle index.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT
) (
  input  logic [N_LOG2-1:0] s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_addr
);

  localparam int TW_W = N_LOG2 - 1;

  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] grp;
  logic [N_LOG2-1:0] base;
  logic [N_LOG2-1:0] tw_shift;

  always_comb begin
    half     = N_LOG2'(1) << s;
    pos      = {1'b0, k} & (half - N_LOG2'(1));
    grp      = {1'b0, k} >> s;
    // Each group spans 2*half entries; bit s of A is always 0, so B is A with bit s set.
    base     = (grp << s) << 1;
    tw_shift = N_LOG2'(TW_W) - s;
    addr_a   = base | pos;
    addr_b   = base | pos | half;
    tw_addr  = TW_W'(pos << tw_shift);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issues one butterfly per cycle through all stages of an in-place radix-2 DIT FFT and
// returns the matching write-back addresses PIPE_LAT cycles later.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2   = N_LOG2_DEFAULT,
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int HALF_N = fft_half_n(N_LOG2);
  localparam int K_W    = N_LOG2 - 1;
  localparam int DW     = $clog2(PIPE_LAT + 1);

  localparam logic [K_W-1:0]    K_LAST     = K_W'(HALF_N - 1);
  localparam logic [N_LOG2-1:0] S_LAST     = N_LOG2'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef struct packed {
    logic              en;
    logic [N_LOG2-1:0] a;
    logic [N_LOG2-1:0] b;
  } wr_req_t;

  fft_state_t        state;
  fft_state_t        state_next;
  logic [N_LOG2-1:0] s_q;
  logic [K_W-1:0]    k_q;
  logic [DW-1:0]     drain_q;
  logic              issue;
  logic              stage_adv;

  logic [N_LOG2-1:0] gen_a;
  logic [N_LOG2-1:0] gen_b;
  logic [N_LOG2-2:0] gen_tw;

  wr_req_t           wr_pipe [PIPE_LAT];

  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .s       (s_q),
    .k       (k_q),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    stage_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        issue = 1'b1;
        if (k_q == K_LAST) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (s_q == S_LAST) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            stage_adv  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // k wraps to 0 on its own after the last butterfly, so each stage starts at k=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      if (state == RUN) k_q <= k_q + K_W'(1);
      drain_q <= (state == DRAIN) ? drain_q + DW'(1) : '0;
      if (state == DONE)  s_q <= '0;
      else if (stage_adv) s_q <= s_q + N_LOG2'(1);
    end
  end

  // Outputs are registered one cycle behind the state that produced them.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      busy  <= (state == RUN) || (state == DRAIN);
      done  <= (state == DONE);
      stage <= (state == IDLE) ? '0 : s_q;
      rd_en <= issue;
      if (issue) begin
        rd_addr_a <= gen_a;
        rd_addr_b <= gen_b;
        tw_addr   <= gen_tw;
      end
    end
  end

  // NOTE: the write delay line is reset, unlike a data RAM, so an aborted run never emits a stray write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) wr_pipe[i] <= '0;
    end else begin
      wr_pipe[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < PIPE_LAT; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign wr_en     = wr_pipe[PIPE_LAT-1].en;
  assign wr_addr_a = wr_pipe[PIPE_LAT-1].a;
  assign wr_addr_b = wr_pipe[PIPE_LAT-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: cycle-level timing model, address-table check on a small
// instance, write-back/hazard checks and a floating-point FFT driven by the DUT's address stream.
module tb_fft_stage_sequencer;

  localparam int LOG2 = 5;
  localparam int PL   = 2;
  localparam int NN   = 1 << LOG2;
  localparam int HN   = NN / 2;
  localparam int T    = LOG2 * (HN + PL) + 1;
  localparam int REC  = T + 4;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic       busy, done, rd_en, wr_en;
  logic [4:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [3:0] tw_addr;

  logic       sm_start;
  logic       sm_busy, sm_done, sm_rd_en, sm_wr_en;
  logic [2:0] sm_stage, sm_rd_a, sm_rd_b, sm_wr_a, sm_wr_b;
  logic [1:0] sm_tw;

  fft_stage_sequencer #(.N_LOG2(LOG2), .PIPE_LAT(PL)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  fft_stage_sequencer #(.N_LOG2(3), .PIPE_LAT(2)) u_small (
    .clk(clk), .reset(reset), .start(sm_start), .busy(sm_busy), .done(sm_done), .stage(sm_stage),
    .rd_en(sm_rd_en), .rd_addr_a(sm_rd_a), .rd_addr_b(sm_rd_b), .tw_addr(sm_tw),
    .wr_en(sm_wr_en), .wr_addr_a(sm_wr_a), .wr_addr_b(sm_wr_b)
  );

  typedef struct packed {
    logic       busy, done, rd_en, wr_en;
    logic [4:0] stage, rd_a, rd_b;
    logic [3:0] tw;
    logic [4:0] wr_a, wr_b;
  } obs_t;

  obs_t obs [REC];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;  o.done = done;  o.rd_en = rd_en;  o.wr_en = wr_en;
    o.stage = stage; o.rd_a = rd_addr_a; o.rd_b = rd_addr_b; o.tw = tw_addr;
    o.wr_a = wr_addr_a; o.wr_b = wr_addr_b;
    return o;
  endfunction

  // Which butterfly (if any) is read in cycle c after a start sampled at edge 0.
  function automatic void read_at(input int c, output bit en, output int s, output int a,
                                  output int b, output int tw);
    int j, k, half, pos;
    en = 0; s = 0; a = 0; b = 0; tw = 0;
    if (c < 1 || c > T - 1) return;
    j = c - 1;
    s = j / (HN + PL);
    k = j % (HN + PL);
    if (k >= HN) return;
    en   = 1;
    half = 1 << s;
    pos  = k % half;
    a    = (k / half) * 2 * half + pos;
    b    = a + half;
    tw   = pos * (NN / (2 * half));
  endfunction

  // Expected outputs for cycle c and the mask of fields that are defined in that cycle.
  function automatic void model(input int c, output obs_t e, output obs_t m);
    bit en, wen;
    int s, a, b, tw, ws, wa, wb, wtw;
    e = '0; m = '0;
    read_at(c, en, s, a, b, tw);
    read_at(c - PL, wen, ws, wa, wb, wtw);
    e.busy = (c >= 1 && c <= T - 1); m.busy = 1'b1;
    e.done = (c == T);               m.done = 1'b1;
    e.rd_en = en;                    m.rd_en = 1'b1;
    e.wr_en = wen;                   m.wr_en = 1'b1;
    if (en) begin
      e.stage = 5'(s); e.rd_a = 5'(a); e.rd_b = 5'(b); e.tw = 4'(tw);
      m.stage = '1;    m.rd_a = '1;    m.rd_b = '1;    m.tw = '1;
    end
    if (wen) begin
      e.wr_a = 5'(wa); e.wr_b = 5'(wb);
      m.wr_a = '1;     m.wr_b = '1;
    end
    if (c == T) begin
      e.stage = 5'(LOG2 - 1); m.stage = '1;
    end else if (c > T) begin
      e.stage = '0; m.stage = '1;
    end
  endfunction

  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < LOG2; b++) r |= ((i >> b) & 1) << (LOG2 - 1 - b);
    return r;
  endfunction

  // Start one FFT and record outputs for cycles 0..REC-1; optional stray starts and a mid-run reset.
  task automatic run_fft(input int stray_a, input int stray_b, input int reset_at);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    obs[0] = sample();
    for (int c = 1; c < REC; c++) begin
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      obs[c] = sample();
      if (c == stray_a || c == stray_b) start = 1'b1;
      if (c == reset_at) reset = 1'b1;
    end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; start = 1'b0; sm_start = 1'b0;
    repeat (3) @(negedge clk);
    o = sample();
    tests_run++;
    if (o !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h, want 0", o);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    o = sample();
    tests_run++;
    if (o !== '0) begin
      tests_failed++; $display("FAIL idle_after_reset: got %h, want 0", o);
    end
  endtask

  task automatic test_small_table();
    int ta [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tt [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    logic       h_en [26];
    logic [2:0] h_a  [26];
    logic [2:0] h_b  [26];
    int n = 0;
    int expc;
    @(negedge clk); sm_start = 1'b1;
    @(negedge clk); sm_start = 1'b0;
    h_en[0] = sm_rd_en; h_a[0] = sm_rd_a; h_b[0] = sm_rd_b;
    for (int c = 1; c < 26; c++) begin
      @(negedge clk);
      h_en[c] = sm_rd_en; h_a[c] = sm_rd_a; h_b[c] = sm_rd_b;
      if (sm_rd_en) begin
        tests_run++;
        expc = 1 + (n / 4) * 6 + (n % 4);
        if (n >= 12) begin
          tests_failed++; $display("FAIL small_extra_read: cycle %0d read #%0d, want 12 reads", c, n);
        end else if (c != expc || sm_rd_a !== 3'(ta[n]) || sm_rd_b !== 3'(tb[n]) ||
                     sm_tw !== 2'(tt[n]) || sm_stage !== 3'(n / 4)) begin
          tests_failed++;
          $display("FAIL small_read_%0d: got cyc=%0d s=%0d (%0d,%0d,%0d), want cyc=%0d s=%0d (%0d,%0d,%0d)",
                   n, c, sm_stage, sm_rd_a, sm_rd_b, sm_tw, expc, n / 4, ta[n], tb[n], tt[n]);
        end
        n++;
      end
      if (c >= 2) begin
        tests_run++;
        if (sm_wr_en !== h_en[c-2] || (h_en[c-2] && (sm_wr_a !== h_a[c-2] || sm_wr_b !== h_b[c-2]))) begin
          tests_failed++;
          $display("FAIL small_write_c%0d: got en=%b (%0d,%0d), want en=%b (%0d,%0d)",
                   c, sm_wr_en, sm_wr_a, sm_wr_b, h_en[c-2], h_a[c-2], h_b[c-2]);
        end
      end
      tests_run++;
      if (sm_done !== (c == 19) || sm_busy !== (c >= 1 && c <= 18)) begin
        tests_failed++;
        $display("FAIL small_done_busy_c%0d: got done=%b busy=%b, want done=%b busy=%b",
                 c, sm_done, sm_busy, c == 19, c >= 1 && c <= 18);
      end
    end
    tests_run++;
    if (n != 12) begin
      tests_failed++; $display("FAIL small_read_count: got %0d, want 12", n);
    end
  endtask

  task automatic test_full_run();
    obs_t e, m;
    int nr = 0, nw = 0;
    run_fft(-1, -1, -1);
    for (int c = 1; c < REC; c++) begin
      model(c, e, m);
      nr += int'(obs[c].rd_en);
      nw += int'(obs[c].wr_en);
      tests_run++;
      if ((obs[c] & m) !== e) begin
        tests_failed++; $display("FAIL full_run_c%0d: got %h, want %h", c, obs[c] & m, e);
      end
    end
    tests_run++;
    if (nr != LOG2 * HN || nw != LOG2 * HN) begin
      tests_failed++; $display("FAIL pulse_count: got rd=%0d wr=%0d, want %0d each", nr, nw, LOG2 * HN);
    end
  endtask

  task automatic test_pipeline();
    int pend [$];
    bit hit;
    run_fft(-1, -1, -1);
    for (int c = 2; c < REC; c++) begin
      tests_run++;
      if (obs[c].wr_en !== obs[c-PL].rd_en ||
          (obs[c].wr_en && (obs[c].wr_a !== obs[c-PL].rd_a || obs[c].wr_b !== obs[c-PL].rd_b))) begin
        tests_failed++;
        $display("FAIL wr_delay_c%0d: got en=%b (%0d,%0d), want en=%b (%0d,%0d)", c, obs[c].wr_en,
                 obs[c].wr_a, obs[c].wr_b, obs[c-PL].rd_en, obs[c-PL].rd_a, obs[c-PL].rd_b);
      end
    end
    for (int c = 1; c < REC; c++) begin
      if (obs[c].rd_en) begin
        hit = 0;
        foreach (pend[i]) if (pend[i] == int'(obs[c].rd_a) || pend[i] == int'(obs[c].rd_b)) hit = 1;
        tests_run++;
        if (hit) begin
          tests_failed++;
          $display("FAIL raw_hazard_c%0d: got read of (%0d,%0d) with write pending, want none pending",
                   c, obs[c].rd_a, obs[c].rd_b);
        end
      end
      if (obs[c].wr_en)
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i] == int'(obs[c].wr_a) || pend[i] == int'(obs[c].wr_b)) pend.delete(i);
      if (obs[c].rd_en) begin
        pend.push_back(int'(obs[c].rd_a));
        pend.push_back(int'(obs[c].rd_b));
      end
    end
  endtask

  task automatic test_stray_start();
    obs_t e, m;
    int sa, sb;
    for (int it = 0; it < 2; it++) begin
      sa = (it == 0) ? 5 : int'($urandom_range(1, T - 2));
      sb = (it == 0) ? 40 : T - 1;
      run_fft(sa, sb, -1);
      for (int c = 1; c < REC; c++) begin
        model(c, e, m);
        tests_run++;
        if ((obs[c] & m) !== e) begin
          tests_failed++;
          $display("FAIL stray_start_%0d_%0d_c%0d: got %h, want %h", sa, sb, c, obs[c] & m, e);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e, m;
    int r;
    for (int it = 0; it < 2; it++) begin
      r = (it == 0) ? 30 : int'($urandom_range(2, T - 2));
      run_fft(-1, -1, r);
      for (int c = 1; c < REC; c++) begin
        if (c <= r) model(c, e, m);
        else begin e = '0; m = '1; end
        tests_run++;
        if ((obs[c] & m) !== e) begin
          tests_failed++;
          $display("FAIL reset_at_%0d_c%0d: got %h, want %h", r, c, obs[c] & m, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, m;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_fft(-1, -1, -1);
      for (int c = 1; c < REC; c++) begin
        model(c, e, m);
        tests_run++;
        if ((obs[c] & m) !== e) begin
          tests_failed++;
          $display("FAIL back_to_back_%0d_c%0d: got %h, want %h", it, c, obs[c] & m, e);
        end
      end
    end
  endtask

  // In-place FFT on random data using the DUT's address stream; reads see RAM before same-cycle writes.
  task automatic test_fft_data();
    real xr [NN], xi [NN], rr [NN], ri [NN];
    real qar [$], qai [$], qbr [$], qbi [$];
    int  qtw [$];
    real ar, ai, br, bi, cw, sw, tr, ti, er, ei, th, dr, di;
    int  m;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < NN; i++) begin
        xr[i] = real'(int'($urandom_range(0, 2000)) - 1000);
        xi[i] = (rep == 0) ? 0.0 : real'(int'($urandom_range(0, 2000)) - 1000);
        rr[bitrev(i)] = xr[i];
        ri[bitrev(i)] = xi[i];
      end
      run_fft(-1, -1, -1);
      for (int c = 1; c < REC; c++) begin
        if (obs[c].rd_en) begin
          qar.push_back(rr[obs[c].rd_a]); qai.push_back(ri[obs[c].rd_a]);
          qbr.push_back(rr[obs[c].rd_b]); qbi.push_back(ri[obs[c].rd_b]);
          qtw.push_back(int'(obs[c].tw));
        end
        if (obs[c].wr_en && qtw.size() > 0) begin
          ar = qar.pop_front(); ai = qai.pop_front();
          br = qbr.pop_front(); bi = qbi.pop_front();
          m  = qtw.pop_front();
          cw = $cos(2.0 * PI * m / NN);
          sw = $sin(2.0 * PI * m / NN);
          tr = br * cw + bi * sw;
          ti = bi * cw - br * sw;
          rr[obs[c].wr_a] = ar + tr; ri[obs[c].wr_a] = ai + ti;
          rr[obs[c].wr_b] = ar - tr; ri[obs[c].wr_b] = ai - ti;
        end
      end
      tests_run++;
      if (qtw.size() != 0) begin
        tests_failed++; $display("FAIL fft_unwritten: got %0d butterflies never written, want 0", qtw.size());
        qar.delete(); qai.delete(); qbr.delete(); qbi.delete(); qtw.delete();
      end
      for (int f = 0; f < NN; f++) begin
        er = 0.0; ei = 0.0;
        for (int n = 0; n < NN; n++) begin
          th = 2.0 * PI * ((f * n) % NN) / NN;
          er += xr[n] * $cos(th) + xi[n] * $sin(th);
          ei += xi[n] * $cos(th) - xr[n] * $sin(th);
        end
        dr = rr[f] - er; di = ri[f] - ei;
        tests_run++;
        if (dr > 1e-6 || dr < -1e-6 || di > 1e-6 || di < -1e-6) begin
          tests_failed++;
          $display("FAIL fft_bin_%0d: got (%f,%f), want (%f,%f)", f, rr[f], ri[f], er, ei);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_small_table();
    test_full_run();
    test_pipeline();
    test_stray_start();
    test_reset_midrun();
    test_back_to_back();
    test_fft_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
